// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: word-addressed memory behind a request FSM. Each request is
// captured on a rising RD/WR level, waits a fixed number of cycles, accesses
// the array, then reports completion through a sticky Done level.
`timescale 1ns/1ps
module mem_access_ctrl #(
    parameter int unsigned WAIT_CYCLES = 3,   // 0..7, wider values are truncated
    parameter int unsigned DEPTH       = 1024
) (
    input  logic        clk,
    input  logic        ar,
    input  logic [9:0]  A,
    input  logic [15:0] DIn,
    input  logic        RD,
    input  logic        WR,
    output logic [15:0] DOut,
    output logic        Done,
    output logic        Busy,
    output logic        Collision
);
    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {StIdle, StWait, StAccess, StFinish} state_e;

    state_e      state_q, state_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        op_wr_q, op_wr_d;
    logic [9:0]  addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic [15:0] dout_q, dout_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic        coll_q, coll_d;

    logic            rd_rise;
    logic            wr_rise;
    logic [IdxW-1:0] idx;

    // Array is deliberately left without reset so contents survive ar.
    logic [15:0] mem [DEPTH];

    assign rd_rise = RD & ~rd_q;
    assign wr_rise = WR & ~wr_q;
    // Address wraps modulo DEPTH rather than flagging out-of-range.
    assign idx     = IdxW'(32'(addr_q) % DEPTH);

    // Next-state and registered-output logic for the request FSM.
    always_comb begin
        state_d = state_q;
        rd_d    = RD;
        wr_d    = WR;
        cnt_d   = cnt_q;
        op_wr_d = op_wr_q;
        addr_d  = addr_q;
        data_d  = data_q;
        dout_d  = dout_q;
        done_d  = done_q;
        coll_d  = coll_q;

        case (state_q)
            StIdle: begin
                if (wr_rise) begin
                    // A simultaneous read is dropped; only the write proceeds.
                    addr_d  = A;
                    data_d  = DIn;
                    op_wr_d = 1'b1;
                    cnt_d   = 3'(WAIT_CYCLES);
                    done_d  = 1'b0;
                    state_d = StWait;
                    if (rd_rise) coll_d = 1'b1;
                end else if (rd_rise) begin
                    addr_d  = A;
                    op_wr_d = 1'b0;
                    cnt_d   = 3'(WAIT_CYCLES);
                    done_d  = 1'b0;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (cnt_q == 3'd0) begin
                    state_d = StAccess;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            StAccess: begin
                if (!op_wr_q) dout_d = mem[idx];
                state_d = StFinish;
            end
            StFinish: begin
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge ar) begin
        if (!ar) begin
            state_q <= StIdle;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            cnt_q   <= 3'd0;
            op_wr_q <= 1'b0;
            addr_q  <= 10'd0;
            data_q  <= 16'd0;
            dout_q  <= 16'd0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            coll_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            op_wr_q <= op_wr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            coll_q  <= coll_d;
        end
    end

    // Array write port; state_q is forced idle under reset so an aborted
    // request never reaches this.
    always_ff @(posedge clk) begin
        if (state_q == StAccess && op_wr_q) begin
            mem[idx] <= data_q;
        end
    end

    assign DOut      = dout_q;
    assign Done      = done_q;
    assign Busy      = busy_q;
    assign Collision = coll_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl: scoreboard of expected completions checked by
// a monitor on each Done rise, plus directed checks and a WAIT_CYCLES=0 copy.
`timescale 1ns/1ps
module tb_mem_access_ctrl;
    localparam int W = 3;

    logic        clk = 1'b0;
    logic        ar  = 1'b0;
    logic [9:0]  a   = '0;
    logic [15:0] din = '0;
    logic        rd  = 1'b0;
    logic        wr  = 1'b0;
    logic [15:0] dout;
    logic        done, busy, coll;

    logic [9:0]  a0   = '0;
    logic [15:0] din0 = '0;
    logic        rd0  = 1'b0;
    logic        wr0  = 1'b0;
    logic [15:0] dout0;
    logic        done0, busy0, coll0;

    mem_access_ctrl #(.WAIT_CYCLES(W), .DEPTH(1024)) u_dut (
        .clk(clk), .ar(ar), .A(a), .DIn(din), .RD(rd), .WR(wr),
        .DOut(dout), .Done(done), .Busy(busy), .Collision(coll)
    );

    mem_access_ctrl #(.WAIT_CYCLES(0), .DEPTH(1024)) u_dut0 (
        .clk(clk), .ar(ar), .A(a0), .DIn(din0), .RD(rd0), .WR(wr0),
        .DOut(dout0), .Done(done0), .Busy(busy0), .Collision(coll0)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [15:0] dout;
        bit          chk;
        int unsigned due;
    } exp_t;
    exp_t sb[$];

    // Reference model: plain array plus the architectural flags.
    logic [15:0] m_mem [1024];
    bit          m_written [1024];
    logic [15:0] last_dout = '0;
    bit          last_ok   = 1'b1;
    bit          m_coll    = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Drive one request at a negedge, hold it `hold` cycles, then idle until the
    // DUT can accept again.
    task automatic issue(input bit do_rd, input bit do_wr, input logic [9:0] addr,
                         input logic [15:0] data, input int hold);
        exp_t e;
        a = addr; din = data; rd = do_rd; wr = do_wr;
        if (do_wr) begin
            m_mem[addr]     = data;
            m_written[addr] = 1'b1;
            if (do_rd) m_coll = 1'b1;
        end else if (do_rd) begin
            if (m_written[addr]) begin
                last_dout = m_mem[addr];
                last_ok   = 1'b1;
            end else begin
                last_ok = 1'b0;
            end
        end
        e.dout = last_dout;
        e.chk  = last_ok;
        e.due  = cyc + 1 + W + 3;
        sb.push_back(e);
        @(negedge clk);
        chk("busy_after_accept", 32'(busy), 32'd1);
        repeat (hold - 1) @(negedge clk);
        rd = 1'b0; wr = 1'b0;
        repeat ((hold < W + 4) ? (W + 4 - hold) : 1) @(negedge clk);
    endtask

    // Monitor: every Done rise must match the oldest outstanding request.
    initial begin
        logic done_prev;
        exp_t e;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (ar && done && !done_prev) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_done: Done rose at cycle %0d with no request pending", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("latency_cycle", cyc, e.due);
                    chk("busy_low_at_done", 32'(busy), 32'd0);
                    if (e.chk) chk("dout", 32'(dout), 32'(e.dout));
                end
            end
            done_prev = done;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0]  ad;
        logic [15:0] dv;
        bit          is_wr;
        int          op;

        // Reset values while ar is held low.
        #1;
        chk("reset_dout", 32'(dout), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_coll", 32'(coll), 32'd0);
        repeat (3) @(negedge clk);
        ar = 1'b1;
        @(negedge clk);

        // WAIT_CYCLES=0 copy: 3-clock latency, requests spaced 4 cycles apart.
        for (int i = 0; i < 6; i++) begin
            is_wr = (i < 3);
            ad    = 10'h010 + 10'(i % 3);
            dv    = 16'hC000 + 16'(i % 3);
            a0 = ad; din0 = dv; rd0 = !is_wr; wr0 = is_wr;
            @(negedge clk);
            rd0 = 1'b0; wr0 = 1'b0;
            chk("w0_done_clear", 32'(done0), 32'd0);
            @(negedge clk);
            @(negedge clk);
            chk("w0_not_early", 32'(done0), 32'd0);
            @(negedge clk);
            chk("w0_done_at_3", 32'(done0), 32'd1);
            if (!is_wr) chk("w0_dout", 32'(dout0), 32'(dv));
        end

        // Write 0xBEEF then read with RD held 8 cycles (must not retrigger).
        issue(1'b0, 1'b1, 10'h005, 16'hBEEF, 1);
        issue(1'b1, 1'b0, 10'h005, 16'h0000, 8);

        // Sweep every address.
        for (int i = 0; i < 1024; i++) issue(1'b0, 1'b1, 10'(i), 16'(i * 15), 1);
        for (int i = 0; i < 1024; i++) issue(1'b1, 1'b0, 10'(i), 16'h0000, 1);
        chk("sweep_no_collision", 32'(coll), 32'(m_coll));

        // Simultaneous rises: write only, sticky Collision.
        issue(1'b1, 1'b1, 10'h3FF, 16'h1234, 1);
        chk("collision_set", 32'(coll), 32'(m_coll));
        issue(1'b1, 1'b0, 10'h3FF, 16'h0000, 1);

        // Request while busy is dropped; address change after capture ignored.
        issue(1'b0, 1'b1, 10'h0A1, 16'h1111, 1);
        issue(1'b0, 1'b1, 10'h0A2, 16'h2222, 1);
        begin
            exp_t e;
            a = 10'h0A1; rd = 1'b1;
            last_dout = m_mem[10'h0A1]; last_ok = 1'b1;
            e.dout = last_dout; e.chk = 1'b1; e.due = cyc + 1 + W + 3;
            sb.push_back(e);
            @(negedge clk); rd = 1'b0;
            @(negedge clk); a = 10'h0A2; din = 16'hDEAD; wr = 1'b1;
            @(negedge clk); wr = 1'b0; a = 10'h000;
            repeat (W + 1) @(negedge clk);
        end
        issue(1'b1, 1'b0, 10'h0A2, 16'h0000, 1);

        // Random traffic against the model.
        for (int i = 0; i < 300; i++) begin
            op = int'($urandom_range(0, 1));
            ad = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, 15));
            issue(op == 0, op == 1, ad, 16'($urandom), int'($urandom_range(1, 3)));
        end

        // Reset during WAIT aborts the write; RD high at release counts as a rise.
        issue(1'b0, 1'b1, 10'h155, 16'h5555, 1);
        a = 10'h155; din = 16'hAAAA; wr = 1'b1;
        @(negedge clk); wr = 1'b0;
        @(negedge clk);
        ar = 1'b0; rd = 1'b1; a = 10'h155;
        #1;
        chk("midreset_dout", 32'(dout), 32'd0);
        chk("midreset_done", 32'(done), 32'd0);
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_coll", 32'(coll), 32'd0);
        m_coll = 1'b0;
        @(negedge clk);
        ar = 1'b1;
        begin
            exp_t e;
            last_dout = m_mem[10'h155]; last_ok = 1'b1;
            e.dout = last_dout; e.chk = 1'b1; e.due = cyc + 1 + W + 3;
            sb.push_back(e);
        end
        @(negedge clk); rd = 1'b0;
        repeat (W + 3) @(negedge clk);

        repeat (W + 10) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        chk("collision_final", 32'(coll), 32'(m_coll));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
